// File: rtl/event_scheduler_if.sv
// Connects the hazard-event scheduler to main_fsm and to the two event blocks.
// The master is the game side: it supplies the phase and the event activity flag.
interface event_scheduler_if;
  logic [2:0] current_state;
  logic       event_active;
  logic       trig_ev1;
  logic       trig_ev2;
  logic [7:0] event_count;
  logic [2:0] sched_state;

  modport master (
    output current_state,
    output event_active,
    input  trig_ev1,
    input  trig_ev2,
    input  event_count,
    input  sched_state
  );

  modport slave (
    input  current_state,
    input  event_active,
    output trig_ev1,
    output trig_ev2,
    output event_count,
    output sched_state
  );
endinterface

// File: rtl/event_scheduler.sv
// Schedules randomised hazard-event start pulses during armed puzzle phases,
// pausing while an event runs and enforcing a cooldown after each one.
module event_scheduler #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned MIN_GAP_S  = 8,
  parameter bit          JITTER_EN  = 1'b1,
  parameter int unsigned COOLDOWN_S = 3,
  parameter int unsigned ACK_WAIT   = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             sys_rst,
  event_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_COUNT    = 3'd2,
    S_FIRE     = 3'd3,
    S_WAIT_ACT = 3'd4,
    S_COOLDOWN = 3'd5
  } state_t;

  localparam int          TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int          ACK_W     = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'((ACK_WAIT > 0) ? ACK_WAIT - 1 : 0);
  localparam logic [5:0]  MIN_GAP6  = 6'(MIN_GAP_S);
  localparam logic [5:0]  COOL_LOAD = (COOLDOWN_S == 0) ? 6'd1 : 6'(COOLDOWN_S);
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  state_t              state;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [5:0]          countdown;
  logic [5:0]          load_val;
  logic [ACK_W-1:0]    ack_cnt;
  logic                ack_seen;
  logic [2:0]          prev_phase;
  logic                trig_ev1_q;
  logic                trig_ev2_q;
  logic [7:0]          event_count_q;

  logic armed;
  logic prev_armed;
  logic phase_change;
  logic run_tick;
  logic tick;

  assign armed        = bus.current_state inside {3'd1, 3'd2, 3'd3};
  assign prev_armed   = prev_phase inside {3'd1, 3'd2, 3'd3};
  assign phase_change = armed && prev_armed && (prev_phase != bus.current_state);

  // The tick counter freezes while an event is running during the gap countdown.
  assign run_tick = (state == S_COOLDOWN) || ((state == S_COUNT) && !bus.event_active);
  assign tick     = run_tick && (tick_cnt == TICK_LAST);

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    load_val = MIN_GAP6;
    if (JITTER_EN) load_val = MIN_GAP6 + {3'b000, lfsr[2:0]};
    if (load_val == 6'd0) load_val = 6'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      lfsr          <= LFSR_INIT;
      tick_cnt      <= '0;
      countdown     <= '0;
      ack_cnt       <= '0;
      ack_seen      <= 1'b0;
      prev_phase    <= '0;
      trig_ev1_q    <= 1'b0;
      trig_ev2_q    <= 1'b0;
      event_count_q <= '0;
    end else begin
      lfsr       <= lfsr_next;
      prev_phase <= bus.current_state;
      trig_ev1_q <= 1'b0;
      trig_ev2_q <= 1'b0;

      if (!armed) begin
        // Disarm wins over everything, including a FIRE due this cycle.
        state     <= S_IDLE;
        tick_cnt  <= '0;
        countdown <= '0;
        ack_cnt   <= '0;
        ack_seen  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            tick_cnt <= '0;
            state    <= S_LOAD;
          end

          S_LOAD: begin
            countdown <= load_val;
            tick_cnt  <= '0;
            state     <= S_COUNT;
          end

          S_COUNT: begin
            if (phase_change) begin
              tick_cnt <= '0;
              state    <= S_LOAD;
            end else if (run_tick) begin
              tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
              if (tick) begin
                if (countdown <= 6'd1) begin
                  // Decide on the LFSR value that will be live during FIRE.
                  trig_ev1_q <= ~lfsr_next[15];
                  trig_ev2_q <=  lfsr_next[15];
                  if (event_count_q != 8'hFF) event_count_q <= event_count_q + 8'd1;
                  countdown  <= '0;
                  state      <= S_FIRE;
                end else begin
                  countdown <= countdown - 6'd1;
                end
              end
            end
          end

          S_FIRE: begin
            ack_cnt  <= '0;
            ack_seen <= 1'b0;
            state    <= S_WAIT_ACT;
          end

          S_WAIT_ACT: begin
            if (ack_cnt != ACK_LAST) ack_cnt <= ack_cnt + ACK_W'(1);
            if (bus.event_active) begin
              ack_seen <= 1'b1;
            end else if (ack_seen || (ack_cnt == ACK_LAST)) begin
              countdown <= COOL_LOAD;
              tick_cnt  <= '0;
              state     <= S_COOLDOWN;
            end
          end

          S_COOLDOWN: begin
            if (phase_change) begin
              tick_cnt <= '0;
              state    <= S_LOAD;
            end else begin
              tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
              if (tick) begin
                if (countdown <= 6'd1) begin
                  countdown <= '0;
                  state     <= S_LOAD;
                end else begin
                  countdown <= countdown - 6'd1;
                end
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.trig_ev1    = trig_ev1_q;
  assign bus.trig_ev2    = trig_ev2_q;
  assign bus.event_count = event_count_q;
  assign bus.sched_state = state;

endmodule

// File: tb/tb_event_scheduler.sv
// Directed timing checks on a jitter-free scheduler, then a randomised run of two
// jittered schedulers (SEED=ACE1 and SEED=0) against a schedule model.
module tb_event_scheduler;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  event_scheduler_if if0 ();
  event_scheduler_if if1 ();
  event_scheduler_if if2 ();

  event_scheduler #(.TICK_DIV(4), .MIN_GAP_S(2), .JITTER_EN(1'b0), .COOLDOWN_S(1),
                    .ACK_WAIT(4), .SEED(16'hACE1))
    dut0 (.clk(clk), .sys_rst(sys_rst), .bus(if0));
  event_scheduler #(.TICK_DIV(4), .MIN_GAP_S(2), .JITTER_EN(1'b1), .COOLDOWN_S(1),
                    .ACK_WAIT(4), .SEED(16'hACE1))
    dut1 (.clk(clk), .sys_rst(sys_rst), .bus(if1));
  event_scheduler #(.TICK_DIV(4), .MIN_GAP_S(2), .JITTER_EN(1'b1), .COOLDOWN_S(1),
                    .ACK_WAIT(4), .SEED(16'h0000))
    dut2 (.clk(clk), .sys_rst(sys_rst), .bus(if2));

  int tests = 0;
  int fails = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample/drive point is the falling edge.
  task automatic step();
    @(negedge clk);
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic wait_trig0(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (if0.trig_ev1 || if0.trig_ev2) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic drive_b(input logic [2:0] cs, input logic act);
    if1.current_state = cs;
    if2.current_state = cs;
    if1.event_active  = act;
    if2.event_active  = act;
  endtask

  task automatic check_b(input string tag, input logic e1, input logic e2, input logic [7:0] ec);
    check({tag, "_ev1_seed_ace1"}, if1.trig_ev1, e1);
    check({tag, "_ev2_seed_ace1"}, if1.trig_ev2, e2);
    check({tag, "_cnt_seed_ace1"}, if1.event_count, ec);
    check({tag, "_ev1_seed_0"}, if2.trig_ev1, e1);
    check({tag, "_ev2_seed_0"}, if2.trig_ev2, e2);
    check({tag, "_cnt_seed_0"}, if2.event_count, ec);
  endtask

  initial begin
    int n;
    int hits;
    logic [2:0] cur_phase;
    logic [7:0] cnt_exp;
    int ev1_n;
    int ev2_n;

    if0.current_state = 3'd0;
    if0.event_active  = 1'b0;
    drive_b(3'd0, 1'b0);

    // Reset values
    sys_rst = 1'b1;
    step();
    step();
    check("rst_trig_ev1", if0.trig_ev1, 0);
    check("rst_trig_ev2", if0.trig_ev2, 0);
    check("rst_event_count", if0.event_count, 0);
    check("rst_sched_state", if0.sched_state, 0);
    sys_rst = 1'b0;
    step();
    step();
    check("idle_while_unarmed", if0.sched_state, 0);

    // Deterministic trigger timing: gap of 2 ticks of 4 cycles
    if0.current_state = 3'd1;
    step();
    check("load_after_arm", if0.sched_state, 1);
    wait_trig0(40, n);
    check("fire_latency", n, 9);
    check("fire_one_hot", if0.trig_ev1 ^ if0.trig_ev2, 1);
    check("fire_state", if0.sched_state, 3);
    check("count_after_1st", if0.event_count, 1);
    step();
    check("pulse_one_cycle", if0.trig_ev1 | if0.trig_ev2, 0);
    check("wait_act_state", if0.sched_state, 4);

    // Handshake: event_active from FIRE+2 for 20 cycles
    step();
    if0.event_active = 1'b1;
    hits = 0;
    repeat (20) begin
      step();
      if (if0.trig_ev1 || if0.trig_ev2) hits++;
    end
    check("no_trig_while_active", hits, 0);
    check("wait_act_held", if0.sched_state, 4);
    if0.event_active = 1'b0;
    step();
    check("cooldown_entry", if0.sched_state, 5);
    repeat (3) step();
    check("cooldown_last_cycle", if0.sched_state, 5);
    step();
    check("load_after_cooldown", if0.sched_state, 1);
    wait_trig0(40, n);
    check("fire_after_cooldown", n, 9);
    check("count_after_2nd", if0.event_count, 2);

    // Missing acknowledge: WAIT_ACT times out after 4 cycles
    repeat (4) step();
    check("ack_timeout_still_waiting", if0.sched_state, 4);
    step();
    check("ack_timeout_cooldown", if0.sched_state, 5);
    wait_trig0(40, n);
    check("fire_after_timeout", n, 13);
    check("count_after_3rd", if0.event_count, 3);

    // Disarm in the cycle before FIRE
    repeat (17) step();
    check("pre_fire_count_state", if0.sched_state, 2);
    if0.current_state = 3'd4;
    step();
    check("disarm_no_trig", if0.trig_ev1 | if0.trig_ev2, 0);
    check("disarm_idle", if0.sched_state, 0);
    check("disarm_count_kept", if0.event_count, 3);
    if0.current_state = 3'd1;
    step();
    check("rearm_load", if0.sched_state, 1);
    repeat (5) step();
    check("mid_count_state", if0.sched_state, 2);
    if0.current_state = 3'd6;
    step();
    check("game_over_idle", if0.sched_state, 0);
    hits = 0;
    repeat (20) begin
      step();
      if (if0.trig_ev1 || if0.trig_ev2) hits++;
    end
    check("game_over_no_trig", hits, 0);

    // Phase change 1 -> 2 on the 6th COUNT cycle restarts the gap
    if0.current_state = 3'd1;
    step();
    check("phase_test_load", if0.sched_state, 1);
    repeat (6) step();
    if0.current_state = 3'd2;
    step();
    check("phase_change_reload", if0.sched_state, 1);
    wait_trig0(40, n);
    check("fire_after_phase_reload", n, 9);
    check("count_after_4th", if0.event_count, 4);

    // Asynchronous reset mid-COUNT, off the clock edge
    repeat (12) step();
    check("pre_reset_count_state", if0.sched_state, 2);
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst_trig_ev1", if0.trig_ev1, 0);
    check("async_rst_trig_ev2", if0.trig_ev2, 0);
    check("async_rst_count", if0.event_count, 0);
    check("async_rst_state", if0.sched_state, 0);
    step();
    sys_rst = 1'b0;
    step();
    check("load_after_reset", if0.sched_state, 1);
    wait_trig0(40, n);
    check("fire_after_reset", n, 9);
    check("count_after_reset", if0.event_count, 1);
    if0.current_state = 3'd0;

    // Randomised run with jitter against the schedule model
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    m_lfsr = 16'hACE1;
    cur_phase = 3'd1;
    drive_b(cur_phase, 1'b0);
    cnt_exp = 8'd0;
    ev1_n = 0;
    ev2_n = 0;
    step();
    for (int r = 0; r < 260; r++) begin
      int gap;
      int fire_off;
      int first;
      int stray;
      int ack;
      int d;
      int h;
      int c_off;
      bit sw;

      // LOAD cycle: gap = MIN_GAP_S + lfsr[2:0] ticks
      check("b_load_seed_ace1", if1.sched_state, 1);
      check("b_load_seed_0", if2.sched_state, 1);
      gap = 2 + int'(m_lfsr[2:0]);
      fire_off = 1 + 4 * gap;
      first = 0;
      stray = 0;
      for (int k = 1; k <= fire_off; k++) begin
        step();
        if (if1.trig_ev1 || if1.trig_ev2) begin
          if (first == 0) first = k;
        end
        if (k < fire_off && (if1.trig_ev1 || if1.trig_ev2 || if2.trig_ev1 || if2.trig_ev2))
          stray++;
      end
      cnt_exp = (cnt_exp == 8'hFF) ? 8'hFF : cnt_exp + 8'd1;
      check_b("b_fire", ~m_lfsr[15], m_lfsr[15], cnt_exp);
      check("b_no_early_trig", stray, 0);
      check("b_gap_ticks_2_to_9",
            (first >= 9 && first <= 37 && ((first - 1) % 4) == 0) ? 1 : 0, 1);
      if (if1.trig_ev1) ev1_n++;
      if (if1.trig_ev2) ev2_n++;

      // Event response: acknowledged (rise d cycles after FIRE, high h) or ignored
      ack = int'($urandom_range(0, 1));
      d = int'($urandom_range(1, 4));
      h = int'($urandom_range(1, 8));
      sw = 1'($urandom_range(0, 1));
      c_off = (ack != 0) ? d + h + 1 : 5;
      stray = 0;
      for (int k = 1; k <= c_off + 4; k++) begin
        step();
        if (k == 1 && sw) cur_phase = (cur_phase == 3'd3) ? 3'd1 : cur_phase + 3'd1;
        drive_b(cur_phase, (ack != 0) && k >= d && k < d + h);
        if (if1.trig_ev1 || if1.trig_ev2 || if2.trig_ev1 || if2.trig_ev2) stray++;
        if (k == c_off) begin
          check("b_cooldown_seed_ace1", if1.sched_state, 5);
          check("b_cooldown_seed_0", if2.sched_state, 5);
        end
      end
      check("b_no_trig_after_fire", stray, 0);
    end
    check("b_ev1_occurs", (ev1_n > 0) ? 1 : 0, 1);
    check("b_ev2_occurs", (ev2_n > 0) ? 1 : 0, 1);
    check("b_count_saturated", if1.event_count, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_scheduler.md
Name: event_scheduler

Overview:
- Decides when the random hazard events start during active puzzle phases.
- Sits between main_fsm (it consumes the current game phase) and the two event blocks (it drives their start pulses).
- Produces one-cycle start pulses with randomised gaps, and pauses while an event is running.
- After each event it enforces a cooldown period before the next one can start.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per scheduler tick (1 s at 50 MHz).
- MIN_GAP_S, 8: minimum ticks between arming or cooldown end and the next trigger.
- JITTER_EN, 1: 1 adds a pseudo-random 0..7 ticks to the gap; 0 adds 0.
- COOLDOWN_S, 3: ticks to wait after an event finishes.
- ACK_WAIT, 4: clk cycles to wait for event_active after a trigger.
- SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous active-high reset
- current_state  in  3  main_fsm phase code (0 idle, 1-4 phases, 5 clear, 6 over)
- event_active  in  1  OR of the event blocks' active flags
- trig_ev1  out  1  one-cycle start pulse for the overload event
- trig_ev2  out  1  one-cycle start pulse for the danger event
- event_count  out  8  triggers issued since reset, saturates at 255
- sched_state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset (async, sys_rst=1):
  - FSM goes to IDLE; tick counter and countdown are cleared.
  - LFSR loads SEED (or 16'hACE1 if SEED=0).
  - Outputs: trig_ev1=0, trig_ev2=0, event_count=0, sched_state=IDLE (0).
- LFSR:
  - 16-bit Galois, mask 16'hB400, shift right.
  - Advances every clk, in every state, independent of arming.
- Arming:
  - armed = (current_state is 1, 2 or 3). Phase 4 and all other codes are unarmed.
- Tick counter:
  - Counts 0..TICK_DIV-1 while in COUNT or COOLDOWN, and is cleared otherwise.
  - tick is asserted in the cycle the counter wraps.
- State encodings: IDLE=0, LOAD=1, COUNT=2, FIRE=3, WAIT_ACT=4, COOLDOWN=5.
- State transitions:
  - IDLE -> LOAD when armed.
  - LOAD (1 cycle): countdown = MIN_GAP_S + (JITTER_EN ? lfsr[2:0] : 0), 6 bits wide. Next state COUNT.
  - COUNT:
    - On tick, countdown decrements.
    - When tick occurs with countdown==1 -> FIRE.
    - While event_active=1, the tick counter holds and does not advance.
  - FIRE (1 cycle):
    - trig_ev1=1 if lfsr[15]==0, else trig_ev2=1; never both.
    - event_count increments, saturating at 255.
    - Next state WAIT_ACT.
  - WAIT_ACT:
    - Once event_active=1 has been seen, wait for event_active=0, then -> COOLDOWN.
    - If event_active stays 0 for ACK_WAIT cycles after FIRE -> COOLDOWN.
  - COOLDOWN: after COOLDOWN_S ticks -> LOAD.
- Output timing:
  - Triggers are registered Moore outputs, high only during the FIRE cycle.
  - Latency: FIRE is exactly 1 + N*TICK_DIV cycles after the LOAD cycle, where N is the loaded countdown (assuming no event_active pause).
- Disarm:
  - If armed=0 in any state, next state is IDLE, counters clear, and no trigger is issued.
  - Disarm has priority over a same-cycle FIRE transition.
  - If disarm occurs during FIRE itself, the pulse already issued stands; event_count is not rolled back.
- Phase change between two armed codes (e.g. 1 -> 2), detected via a registered previous current_state:
  - From COUNT or COOLDOWN -> LOAD, giving a fresh gap.
  - From WAIT_ACT: no change.
- MIN_GAP_S=0 with jitter 0: countdown is forced to 1 (a minimum of one tick).
- Reset mid-operation: immediate return to reset values, with no trigger glitch.

Test Plan:
- Deterministic trigger timing. Params TICK_DIV=4, MIN_GAP_S=2, JITTER_EN=0, COOLDOWN_S=1. Apply reset, then hold current_state=1.
  - LOAD occurs 1 cycle after arming.
  - A single-cycle trig pulse (ev1 or ev2, never both) occurs exactly 9 cycles after LOAD.
  - event_count=1.
- Handshake and cooldown. Same params; bench drives event_active=1 two cycles after the trigger, holds it 20 cycles, then releases it.
  - No trigger while event_active is high.
  - After release: COOLDOWN (4 cycles), then LOAD, then the next trigger 9 cycles after that LOAD.
- Missing acknowledge. event_active held at 0 after the trigger.
  - WAIT_ACT exits after 4 cycles.
  - The next trigger occurs 4 + 1 + 4 + 9 cycles after the first.
- Disarm races. Set current_state=4 in the cycle before FIRE would occur.
  - No trigger is issued; sched_state returns to IDLE (0).
  - Setting current_state=6 mid-COUNT also gives IDLE and trig=0.
- Phase change reload. Switch current_state 1 -> 2 at the 6th cycle of COUNT.
  - LOAD is re-entered and the trigger is pushed out to 9 cycles after that new LOAD.
  - With JITTER_EN=1 over 200 triggers, every gap is within 2..9 ticks and both ev1 and ev2 occur.
- Asynchronous reset. Pulse sys_rst mid-COUNT, not aligned to clk.
  - All outputs go to 0 immediately.
  - A run with SEED=0 behaves identically to SEED=16'hACE1.
